// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for the 5-stage pipeline.
// It drives write-enable and flush for IF/ID, ID/EX, EX/MEM and MEM/WB, plus
// the PC write enable. It resolves halt drain, data-memory waits, taken
// branches/jumps, load-use hazards and instruction-fetch misses in that
// priority order. A watchdog flags data-memory waits that run too long.
//
// Optional feature macro: PIPE_PERF_CNT_EN
//   defined   -> stall_cnt / flush_cnt are live 32-bit event counters
//   undefined -> both ports are tied to zero and no counter flops exist
module pipeline_ctrl #(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        exmem_memread,
    input  logic        exmem_memwrite,
    input  logic        branch_taken,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rt,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        halt_wb,
    output logic        pc_wen,
    output logic        ifid_wen,
    output logic        ifid_flush,
    output logic        idex_wen,
    output logic        idex_flush,
    output logic        exmem_wen,
    output logic        exmem_flush,
    output logic        memwb_wen,
    output logic        memwb_flush,
    output logic        halt,
    output logic        mem_timeout,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

    state_t           state;
    logic [CNT_W-1:0] wcnt;
    logic             mem_busy;
    logic             load_use;

    // A data access is outstanding in MEM and has not completed this cycle.
    assign mem_busy = (exmem_memread | exmem_memwrite) & ~dhit;

    // The load in EX writes a register the instruction in ID is about to read.
    assign load_use = idex_memread & (idex_rt != 5'd0) &
                      ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

    // Zero-latency control decode from the current state and hazard inputs.
    always_comb begin
        pc_wen      = 1'b0;
        ifid_wen    = 1'b0;
        idex_wen    = 1'b0;
        exmem_wen   = 1'b0;
        memwb_wen   = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (!nRST) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else begin
            unique case (state)
                INIT: begin
                    ifid_wen    = 1'b1;
                    idex_wen    = 1'b1;
                    exmem_wen   = 1'b1;
                    memwb_wen   = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    memwb_flush = 1'b1;
                end
                RUN: begin
                    if (!(halt_wb || mem_busy)) begin
                        pc_wen    = 1'b1;
                        ifid_wen  = 1'b1;
                        idex_wen  = 1'b1;
                        exmem_wen = 1'b1;
                        memwb_wen = 1'b1;
                        if (branch_taken) begin
                            ifid_flush  = 1'b1;
                            idex_flush  = 1'b1;
                            exmem_flush = 1'b1;
                        end else if (load_use) begin
                            pc_wen     = 1'b0;
                            ifid_wen   = 1'b0;
                            idex_flush = 1'b1;
                        end else if (!ihit) begin
                            pc_wen     = 1'b0;
                            ifid_flush = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Sequencer: one clearing INIT cycle, then RUN until a halt drains to WB.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= INIT;
            halt  <= 1'b0;
        end else begin
            unique case (state)
                INIT: state <= RUN;
                RUN: begin
                    if (halt_wb) begin
                        state <= HALT;
                        halt  <= 1'b1;
                    end
                end
                default: begin
                    state <= HALT;
                    halt  <= 1'b1;
                end
            endcase
        end
    end

    // Watchdog: count consecutive busy RUN cycles and latch a sticky timeout.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wcnt        <= '0;
            mem_timeout <= 1'b0;
        end else begin
            if (!mem_busy) begin
                wcnt <= '0;
            end else if (state == RUN && wcnt != LIMIT) begin
                wcnt <= wcnt + CNT_W'(1);
            end
            if (mem_busy && wcnt == LIMIT) begin
                mem_timeout <= 1'b1;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    // Performance counters: PC-stalled RUN cycles and taken-branch squashes.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (state == RUN && !halt_wb) begin
            if (!pc_wen) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (!mem_busy && branch_taken) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and randomized checks of pipeline_ctrl against
// a rule-level reference model. Inputs change after the falling edge and
// outputs are sampled 1 ns later, well clear of the rising edge.
module tb_pipeline_ctrl;

    localparam int WAIT_LIMIT = 3;
    localparam int CNT_W      = 16;

    logic        CLK;
    logic        nRST;
    logic        ihit, dhit, exmem_memread, exmem_memwrite, branch_taken;
    logic        idex_memread, halt_wb;
    logic [4:0]  idex_rt, ifid_rs, ifid_rt;
    logic        pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush;
    logic        exmem_wen, exmem_flush, memwb_wen, memwb_flush;
    logic        halt, mem_timeout;
    logic [31:0] stall_cnt, flush_cnt;

    int nvec;
    int nerr;

    // Reference model state, kept in terms of the rules rather than states.
    bit          m_in_reset;
    int          m_cycles;
    bit          m_halted;
    int          m_wait;
    bit          m_timeout;
    int unsigned m_stalls;
    int unsigned m_flushes;

    pipeline_ctrl #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
        .branch_taken(branch_taken), .idex_memread(idex_memread),
        .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .halt_wb(halt_wb), .pc_wen(pc_wen),
        .ifid_wen(ifid_wen), .ifid_flush(ifid_flush),
        .idex_wen(idex_wen), .idex_flush(idex_flush),
        .exmem_wen(exmem_wen), .exmem_flush(exmem_flush),
        .memwb_wen(memwb_wen), .memwb_flush(memwb_flush),
        .halt(halt), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [8:0] obsCtrl();
        return {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
                ifid_flush, idex_flush, exmem_flush, memwb_flush};
    endfunction

    function automatic bit busyNow();
        return (exmem_memread || exmem_memwrite) && !dhit;
    endfunction

    function automatic bit hazardNow();
        return idex_memread && idex_rt != 0 &&
               (idex_rt == ifid_rs || idex_rt == ifid_rt);
    endfunction

    // Expected {pc, wen x4 (IF/ID..MEM/WB), flush x4 (IF/ID..MEM/WB)}.
    function automatic logic [8:0] expCtrl();
        bit       pc;
        bit [3:0] wen, fl;
        if (m_in_reset)    begin pc = 0; wen = 4'b0000; fl = 4'b1111; end
        else if (m_halted) begin pc = 0; wen = 4'b0000; fl = 4'b0000; end
        else if (m_cycles == 0) begin pc = 0; wen = 4'b1111; fl = 4'b1111; end
        else begin
            pc = 1; wen = 4'b1111; fl = 4'b0000;
            if (halt_wb || busyNow()) begin pc = 0; wen = 4'b0000; end
            else if (branch_taken) fl = 4'b1110;
            else if (hazardNow()) begin pc = 0; wen = 4'b0111; fl = 4'b0100; end
            else if (!ihit) begin pc = 0; fl = 4'b1000; end
        end
        return {pc, wen, fl};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        int unsigned es, ef;
`ifdef PIPE_PERF_CNT_EN
        es = m_stalls;
        ef = m_flushes;
`else
        es = 0;
        ef = 0;
`endif
        checkOutput("ctrl", {23'd0, obsCtrl()}, {23'd0, expCtrl()});
        checkOutput("halt", {31'd0, halt}, {31'd0, m_halted});
        checkOutput("mem_timeout", {31'd0, mem_timeout}, {31'd0, m_timeout});
        checkOutput("stall_cnt", stall_cnt, es);
        checkOutput("flush_cnt", flush_cnt, ef);
    endtask

    // Advance the model across one rising edge using the inputs present there.
    task automatic updateModel();
        bit running, busy, old_at_limit;
        logic [8:0] c;
        c = expCtrl();
        running = !m_halted && m_cycles > 0;
        busy = busyNow();
        old_at_limit = (m_wait == WAIT_LIMIT);
        if (running && !halt_wb && c[8] == 1'b0) m_stalls++;
        if (running && !halt_wb && !busy && branch_taken) m_flushes++;
        if (!busy) m_wait = 0;
        else if (running && m_wait < WAIT_LIMIT) m_wait++;
        if (busy && old_at_limit) m_timeout = 1;
        if (running && halt_wb) m_halted = 1;
        m_cycles++;
    endtask

    task automatic applyStimulus(input bit ih, input bit dh, input bit emr,
                                 input bit emw, input bit br, input bit imr,
                                 input logic [4:0] rt, input logic [4:0] rs,
                                 input logic [4:0] frt, input bit hw);
        @(negedge CLK);
        ihit = ih; dhit = dh; exmem_memread = emr; exmem_memwrite = emw;
        branch_taken = br; idex_memread = imr; idex_rt = rt;
        ifid_rs = rs; ifid_rt = frt; halt_wb = hw;
        #1;
        checkAll();
        @(posedge CLK);
        updateModel();
    endtask

    // Assert reset between edges, check reset values, release before INIT.
    task automatic doReset();
        @(negedge CLK);
        #1;
        nRST = 1'b0;
        m_in_reset = 1; m_cycles = 0; m_halted = 0; m_wait = 0;
        m_timeout = 0; m_stalls = 0; m_flushes = 0;
        #1;
        checkOutput("reset_ctrl", {23'd0, obsCtrl()}, 32'h0000_000f);
        checkAll();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        m_in_reset = 0;
    endtask

    task automatic randomStep();
        applyStimulus($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1,
                      $urandom_range(9, 0) < 3, $urandom_range(9, 0) < 2,
                      $urandom_range(9, 0) < 2, $urandom_range(9, 0) < 4,
                      5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
                      5'($urandom_range(3, 0)), $urandom_range(49, 0) == 0);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        nRST = 1'b0;
        ihit = 1; dhit = 1; exmem_memread = 0; exmem_memwrite = 0;
        branch_taken = 0; idex_memread = 0; idex_rt = 0; ifid_rs = 0;
        ifid_rt = 0; halt_wb = 0;
        m_in_reset = 1;

        doReset();
        // INIT cycle: every register cleared, PC held.
        @(negedge CLK);
        #1;
        checkOutput("init_ctrl", {23'd0, obsCtrl()}, 32'h0000_00ff);
        @(posedge CLK);
        updateModel();
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // Load-use on rs, then the same with rt=0 (no hazard).
        applyStimulus(1, 1, 0, 0, 0, 1, 5, 5, 1, 0);
        applyStimulus(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        // Data-memory wait long enough to trip the watchdog, then completion.
        repeat (WAIT_LIMIT + 1) applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("timeout_sticky", {31'd0, mem_timeout}, 32'd1);
        // Branch wins over fetch miss and load-use.
        applyStimulus(0, 1, 0, 0, 1, 1, 7, 7, 0, 0);
        // Fetch miss for four cycles.
        repeat (4) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // Halt during a data wait, then stay halted.
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) applyStimulus(1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("halt_held", {31'd0, halt}, 32'd1);
        doReset();

        // Randomized run with occasional reset pulses.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(79, 0) == 0) doReset();
            randomStep();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
